// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback arbiter: widths, writeback
// request record and arbiter state encoding.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of buffered load returns; head is visible combinationally so
// the arbiter can write it in the same cycle it pops.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t     mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is legal only when the head leaves this cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file write port arbiter: ALU has priority, load returns are
// bypassed or buffered, and a starvation timer forces a drain of the buffer.
module regfile_wb_arb
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alu_valid_i,
  input  logic [REG_AW-1:0] alu_rd_i,
  input  logic [XLEN-1:0]   alu_data_i,
  output logic              alu_stall_o,
  input  logic              lsu_valid_i,
  input  logic [REG_AW-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic              lsu_ready_o,
  input  logic              ld_issue_i,
  input  logic [REG_AW-1:0] ld_rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              hazard_o,
  output logic              rf_wen_o,
  output logic [REG_AW-1:0] rf_rd_o,
  output logic [XLEN-1:0]   rf_data_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [NREGS-1:0] busy_q, busy_d;

  wb_req_t fifo_head, wr_req;
  logic    fifo_full, fifo_empty, fifo_push;
  logic    sel_alu, sel_pop, sel_byp;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i ('{rd: lsu_rd_i, data: lsu_data_i}),
    .pop_i       (sel_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    sel_alu = 1'b0;
    sel_pop = 1'b0;
    sel_byp = 1'b0;
    if (state_q == ST_DRAIN)  sel_pop = !fifo_empty;
    else if (alu_valid_i)     sel_alu = 1'b1;
    else if (!fifo_empty)     sel_pop = 1'b1;
    else if (lsu_valid_i)     sel_byp = 1'b1;

    if (sel_alu)      wr_req = '{rd: alu_rd_i, data: alu_data_i};
    else if (sel_pop) wr_req = fifo_head;
    else              wr_req = '{rd: lsu_rd_i, data: lsu_data_i};

    lsu_ready_o = !rst_i && (!fifo_full || sel_pop);
    fifo_push   = lsu_valid_i && lsu_ready_o && !sel_byp;
    rf_wen_o    = !rst_i && (sel_alu || sel_pop || sel_byp) && (wr_req.rd != '0);
    rf_rd_o     = wr_req.rd;
    rf_data_o   = wr_req.data;
    alu_stall_o = !rst_i && (state_q == ST_DRAIN) && alu_valid_i;
    hazard_o    = !rst_i && (busy_q[rs1_i] || busy_q[rs2_i]);

    // Issue is applied after the writeback clear so a same-cycle set wins.
    busy_d = busy_q;
    if (sel_pop || sel_byp) busy_d[wr_req.rd] = 1'b0;
    if (ld_issue_i)         busy_d[ld_rd_i]   = 1'b1;
    busy_d[0] = 1'b0;

    if (fifo_empty || sel_pop) wait_d = '0;
    else if (wait_q < LIMIT)   wait_d = wait_q + 1'b1;
    else                       wait_d = wait_q;

    state_d = ST_NORMAL;
    if (state_q == ST_NORMAL && wait_q == LIMIT && !sel_pop) state_d = ST_DRAIN;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_NORMAL;
      wait_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: vector table, scoreboard of
// expected register-file writes, and hand-built multi-cycle sequences.
module tb_regfile_wb_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i, lsu_valid_i, ld_issue_i;
  logic [4:0]  alu_rd_i, lsu_rd_i, ld_rd_i, rs1_i, rs2_i;
  logic [31:0] alu_data_i, lsu_data_i;
  logic        alu_stall_o, lsu_ready_o, hazard_o, rf_wen_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;

  always #5 clk_i = ~clk_i;

  regfile_wb_arb #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .alu_stall_o(alu_stall_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .lsu_ready_o(lsu_ready_o),
    .ld_issue_i(ld_issue_i), .ld_rd_i(ld_rd_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o),
    .rf_wen_o(rf_wen_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        exp_wen;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_buf;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Every committed write must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (!rst_i && rf_wen_o) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got rd=%0d data=%h, required no write", rf_rd_o, rf_data_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.rd !== rf_rd_o || e.data !== rf_data_o) begin
          n_err++;
          $display("FAIL sb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_rd_o, rf_data_o, e.rd, e.data);
        end
      end
    end
  end

  task automatic idle();
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
    ld_issue_i  = 1'b0; ld_rd_i  = '0;
    rs1_i = '0; rs2_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  vec_t vecs[7];

  initial begin
    int adata;
    vecs[0] = '{1'b1, 5'd5, 32'h11,   1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h11,        1'b0};
    vecs[1] = '{1'b1, 5'd0, 32'h1,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 5'd7, 32'hDEADBEEF,  1'b0};
    vecs[3] = '{1'b1, 5'd2, 32'h22,   1'b1, 5'd8, 32'h88,       1'b1, 5'd2, 32'h22,        1'b1};
    vecs[4] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h5,        1'b0, 5'd0, 32'h0,         1'b0};
    vecs[5] = '{1'b1, 5'd0, 32'h0,    1'b1, 5'd6, 32'h66,       1'b0, 5'd0, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,         1'b0};

    // Outputs are forced quiet while reset is held, even with requests present.
    idle();
    rst_i = 1'b1;
    alu_valid_i = 1'b1; alu_rd_i = 5'd3; lsu_valid_i = 1'b1; lsu_rd_i = 5'd4;
    #2;
    chk("rst_wen",   rf_wen_o,    1'b0);
    chk("rst_stall", alu_stall_o, 1'b0);
    chk("rst_ready", lsu_ready_o, 1'b0);
    chk("rst_haz",   hazard_o,    1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    idle();
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      next_cycle();
      alu_valid_i = vecs[i].alu_v; alu_rd_i = vecs[i].alu_rd; alu_data_i = vecs[i].alu_data;
      lsu_valid_i = vecs[i].lsu_v; lsu_rd_i = vecs[i].lsu_rd; lsu_data_i = vecs[i].lsu_data;
      if (vecs[i].exp_wen) sb_q.push_back('{vecs[i].exp_rd, vecs[i].exp_data});
      if (vecs[i].exp_buf && vecs[i].lsu_rd != 0) sb_q.push_back('{vecs[i].lsu_rd, vecs[i].lsu_data});
      @(negedge clk_i);
      chk($sformatf("vec%0d_wen", i),   rf_wen_o,    vecs[i].exp_wen);
      chk($sformatf("vec%0d_stall", i), alu_stall_o, 1'b0);
      chk($sformatf("vec%0d_ready", i), lsu_ready_o, 1'b1);
      if (vecs[i].exp_wen) chk($sformatf("vec%0d_rd", i), rf_rd_o, vecs[i].exp_rd);
      next_cycle();
      idle();
      @(negedge clk_i);
    end

    // Load-use hazard tracking on both source ports.
    next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd9; rs1_i = 5'd9;
    @(negedge clk_i); chk("haz_before_set", hazard_o, 1'b0);
    next_cycle(); ld_issue_i = 1'b0;
    @(negedge clk_i); chk("haz_rs1", hazard_o, 1'b1);
    next_cycle(); rs1_i = 5'd0; rs2_i = 5'd9;
    @(negedge clk_i); chk("haz_rs2", hazard_o, 1'b1);
    next_cycle(); rs2_i = 5'd0; rs1_i = 5'd9;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h99;
    sb_q.push_back('{5'd9, 32'h99});
    @(negedge clk_i); chk("haz_during_wb", hazard_o, 1'b1); chk("haz_wb_wen", rf_wen_o, 1'b1);
    next_cycle(); lsu_valid_i = 1'b0;
    @(negedge clk_i); chk("haz_cleared", hazard_o, 1'b0);

    // Same-cycle issue and writeback of r9: the issue must stick.
    next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd9;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h999;
    sb_q.push_back('{5'd9, 32'h999});
    @(negedge clk_i);
    next_cycle(); ld_issue_i = 1'b0; lsu_valid_i = 1'b0;
    @(negedge clk_i); chk("set_wins", hazard_o, 1'b1);
    next_cycle(); lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h9A;
    sb_q.push_back('{5'd9, 32'h9A});
    @(negedge clk_i);
    next_cycle(); lsu_valid_i = 1'b0;
    @(negedge clk_i); chk("set_wins_clear", hazard_o, 1'b0);

    // x0 is never marked busy.
    next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd0; rs1_i = 5'd0;
    @(negedge clk_i);
    next_cycle(); ld_issue_i = 1'b0;
    @(negedge clk_i); chk("x0_never_busy", hazard_o, 1'b0);
    next_cycle(); idle();

    // Starvation: ALU requests every cycle, two load returns fill the buffer.
    adata = 32'h1000;
    for (int c = 0; c < 14; c++) begin
      bit stall_exp;
      next_cycle();
      stall_exp   = (c == 6) || (c == 12);
      alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'(adata);
      lsu_valid_i = (c < 2);
      lsu_rd_i    = (c == 0) ? 5'd3 : 5'd4;
      lsu_data_i  = (c == 0) ? 32'h300 : 32'h400;
      if (c == 6)       sb_q.push_back('{5'd3, 32'h300});
      else if (c == 12) sb_q.push_back('{5'd4, 32'h400});
      else              sb_q.push_back('{5'd1, 32'(adata)});
      @(negedge clk_i);
      chk($sformatf("starve_c%0d_stall", c), alu_stall_o, stall_exp);
      chk($sformatf("starve_c%0d_ready", c), lsu_ready_o, !(c >= 2 && c <= 5));
      chk($sformatf("starve_c%0d_rd", c), rf_rd_o, (c == 6) ? 5'd3 : (c == 12) ? 5'd4 : 5'd1);
      if (!stall_exp) adata++;
    end
    next_cycle(); idle();
    @(negedge clk_i); chk("starve_empty_wen", rf_wen_o, 1'b0);

    // Asynchronous reset with two buffered returns and r5 busy.
    next_cycle(); ld_issue_i = 1'b1; ld_rd_i = 5'd5;
    alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'hA;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 32'hAA;
    sb_q.push_back('{5'd1, 32'hA});
    @(negedge clk_i);
    next_cycle(); ld_issue_i = 1'b0;
    alu_data_i = 32'hB; lsu_rd_i = 5'd11; lsu_data_i = 32'hBB;
    sb_q.push_back('{5'd1, 32'hB});
    @(negedge clk_i); chk("pre_rst_ready", lsu_ready_o, 1'b1);
    next_cycle(); alu_data_i = 32'hC; lsu_valid_i = 1'b0; rs1_i = 5'd5;
    #1; chk("pre_rst_haz", hazard_o, 1'b1);
    chk("pre_rst_full_ready", lsu_ready_o, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("async_rst_wen",   rf_wen_o,    1'b0);
    chk("async_rst_ready", lsu_ready_o, 1'b0);
    chk("async_rst_haz",   hazard_o,    1'b0);
    chk("async_rst_stall", alu_stall_o, 1'b0);
    next_cycle(); rst_i = 1'b0; idle(); rs1_i = 5'd5;
    @(negedge clk_i);
    chk("post_rst_wen",   rf_wen_o,    1'b0);
    chk("post_rst_haz",   hazard_o,    1'b0);
    chk("post_rst_ready", lsu_ready_o, 1'b1);
    next_cycle();
    @(negedge clk_i); chk("post_rst_wen2", rf_wen_o, 1'b0);

    next_cycle(); idle();
    @(negedge clk_i);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
